// File: rtl/spi_master_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_master_multi                                                |
// | Purpose  : Parametrised full-duplex, MSB-first SPI master. Supports a      |
// |            configurable word width, runtime CPOL/CPHA, a programmable SCLK |
// |            half-period (H = clk_div_i + 1 pllClk_i cycles) and one-hot     |
// |            active-low chip selects. One transfer per accepted start.       |
// | Ports    : pllClk_i / Rst_i_n        clock, async active-low reset        |
// |            start_i                   transfer request (sampled in IDLE)   |
// |            cs_sel_i                  target slave index (>= NUM_CS: none) |
// |            cpol_i / cpha_i           SPI mode for the transfer            |
// |            clk_div_i                 SCLK half-period minus one           |
// |            tx_data_i / rx_data_o     transmit word / last received word   |
// |            busy_o / done_o           activity flag / completion pulse     |
// |            sclk_o / mosi_o / miso_i  SPI pins                             |
// |            cs_n_o                    active-low chip selects              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module spi_master_multi #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CS     = 4,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                                          pllClk_i,
  input  logic                                          Rst_i_n,
  input  logic                                          start_i,
  input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] cs_sel_i,
  input  logic                                          cpol_i,
  input  logic                                          cpha_i,
  input  logic [DIV_WIDTH-1:0]                          clk_div_i,
  input  logic [DATA_WIDTH-1:0]                         tx_data_i,
  output logic                                          busy_o,
  output logic                                          done_o,
  output logic [DATA_WIDTH-1:0]                         rx_data_o,
  output logic                                          sclk_o,
  output logic                                          mosi_o,
  input  logic                                          miso_i,
  output logic [NUM_CS-1:0]                             cs_n_o
);

  // Half-period index inside XFER runs 0 .. 2*DATA_WIDTH-1.
  localparam int              HC_W        = $clog2(2 * DATA_WIDTH);
  localparam logic [HC_W-1:0] LAST_HALF   = HC_W'(2 * DATA_WIDTH - 1);
  localparam logic [HC_W-1:0] PENULT_HALF = HC_W'(2 * DATA_WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e                  state_q;
  logic [DIV_WIDTH-1:0]    cnt_q;
  logic [DIV_WIDTH-1:0]    div_q;
  logic [HC_W-1:0]         hcnt_q;
  logic                    cpol_q;
  logic                    cpha_q;
  logic [DATA_WIDTH-1:0]   sh_q;
  logic [DATA_WIDTH-1:0]   rx_sh_q;
  logic                    sclk_q;
  logic                    mosi_q;
  logic [NUM_CS-1:0]       cs_n_q;
  logic                    busy_q;
  logic                    done_q;
  logic [DATA_WIDTH-1:0]   rx_data_q;

  // Chip-select pattern for the incoming request; an out-of-range index
  // leaves every select deasserted (dummy clocking).
  logic [NUM_CS-1:0] cs_n_d;
  always_comb begin
    cs_n_d = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(cs_sel_i) == i) cs_n_d[i] = 1'b0;
    end
  end

  // SCLK edges happen at every half-period boundary from SETUP->XFER up to,
  // but not including, the XFER->HOLD boundary. Edge 1 is the SETUP exit;
  // in XFER the edge number is hcnt_q+2, so odd hcnt_q means a leading edge.
  logic half_end;
  logic sclk_edge;
  logic lead_edge;
  logic last_edge;
  logic sample_en;
  logic shift_en;

  assign half_end  = (cnt_q == div_q);
  assign sclk_edge = half_end &&
                     ((state_q == SETUP) || ((state_q == XFER) && (hcnt_q != LAST_HALF)));
  assign lead_edge = (state_q == SETUP) || hcnt_q[0];
  assign last_edge = (state_q == XFER) && (hcnt_q == PENULT_HALF);
  assign sample_en = sclk_edge && (cpha_q ? !lead_edge : lead_edge);
  // CPHA=0 never shifts on the final trailing edge, so mosi keeps the LSB.
  assign shift_en  = sclk_edge && (cpha_q ? lead_edge : (!lead_edge && !last_edge));

  always_ff @(posedge pllClk_i or negedge Rst_i_n) begin
    if (!Rst_i_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      hcnt_q    <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      sh_q      <= '0;
      rx_sh_q   <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_data_q <= '0;
    end else begin
      done_q <= 1'b0;

      if (sclk_edge) sclk_q <= ~sclk_q;
      if (sample_en) rx_sh_q <= {rx_sh_q[DATA_WIDTH-2:0], miso_i};
      if (shift_en) begin
        mosi_q <= sh_q[DATA_WIDTH-1];
        sh_q   <= {sh_q[DATA_WIDTH-2:0], 1'b0};
      end

      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= SETUP;
            busy_q  <= 1'b1;
            cs_n_q  <= cs_n_d;
            cpol_q  <= cpol_i;
            cpha_q  <= cpha_i;
            div_q   <= clk_div_i;
            cnt_q   <= '0;
            hcnt_q  <= '0;
            sclk_q  <= cpol_i;
            mosi_q  <= tx_data_i[DATA_WIDTH-1];
            // CPHA=1 re-presents the MSB on the first leading edge, so the
            // shifter keeps it; CPHA=0 already shows it and starts one bit on.
            sh_q    <= cpha_i ? tx_data_i : {tx_data_i[DATA_WIDTH-2:0], 1'b0};
          end
        end
        SETUP: begin
          if (half_end) begin
            cnt_q   <= '0;
            state_q <= XFER;
          end else begin
            cnt_q <= cnt_q + DIV_WIDTH'(1);
          end
        end
        XFER: begin
          if (half_end) begin
            cnt_q <= '0;
            if (hcnt_q == LAST_HALF) begin
              state_q <= HOLD;
            end else begin
              hcnt_q <= hcnt_q + HC_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + DIV_WIDTH'(1);
          end
        end
        HOLD: begin
          if (half_end) begin
            state_q   <= IDLE;
            cs_n_q    <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            rx_data_q <= rx_sh_q;
            sclk_q    <= cpol_q;
          end else begin
            cnt_q <= cnt_q + DIV_WIDTH'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rx_data_o = rx_data_q;
  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;
  assign cs_n_o    = cs_n_q;

endmodule
`default_nettype wire
